pll_reconf_seq: RTL and testbench

PLL_RECONF_SEQ -- requirements
Module: pll_reconf_seq

---
 rtl/cbm2_pll_pkg.sv | 37 +++
 rtl/sel_filter.sv | 55 +++++
 rtl/pll_reconf_seq.sv | 135 +++++++++++++
 tb/tb_pll_reconf_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cbm2_pll_pkg.sv
// rtl/cbm2_pll_pkg.sv - shared states, pll_cfg register map and fractional-K defaults
package cbm2_pll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_MODE,
        GAP1,
        WR_FRAC,
        GAP2,
        WR_START,
        WAIT_DONE
    } pll_state_e;

    localparam logic [5:0]  ADDR_MODE  = 6'd0;
    localparam logic [5:0]  ADDR_START = 6'd2;
    localparam logic [5:0]  ADDR_FRAC  = 6'd7;

    localparam logic [31:0] K_PAL_DEFAULT  = 32'd1503512573;
    localparam logic [31:0] K_NTSC_DEFAULT = 32'd3357876127;
    localparam logic [31:0] K_BUS_DEFAULT  = 32'd0;

    // sel is {model, ntsc}; Business ignores the video standard
    function automatic logic [31:0] select_k(
        input logic [1:0]  sel,
        input logic [31:0] k_pal,
        input logic [31:0] k_ntsc,
        input logic [31:0] k_bus
    );
        if (sel[1])
            return k_bus;
        else if (sel[0])
            return k_ntsc;
        else
            return k_pal;
    endfunction

endpackage

// File: rtl/sel_filter.sv
// rtl/sel_filter.sv - 2-flop synchroniser and stability filter for {model, ntsc}
module sel_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ntsc,
    input  logic       model,
    output logic [1:0] sel_acc,
    output logic       sel_valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_prev;
    logic [1:0]    r_acc;
    logic          r_valid;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    // r_cnt counts consecutive samples equal to the previous one, saturating
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_sync2 != r_prev)
            w_cnt_next = CW'(1);
        else if (r_cnt != CW'(STABLE_CYCLES))
            w_cnt_next = r_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_prev  <= 2'b00;
            r_acc   <= 2'b00;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= {model, ntsc};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_cnt   <= w_cnt_next;
            if (w_cnt_next == CW'(STABLE_CYCLES)) begin
                r_acc   <= r_sync2;
                r_valid <= 1'b1;
            end
        end
    end

    assign sel_acc   = r_acc;
    assign sel_valid = r_valid;

endmodule

// File: rtl/pll_reconf_seq.sv
// rtl/pll_reconf_seq.sv - reprograms the pll_cfg fractional-K word when the video/model selection changes
module pll_reconf_seq
    import cbm2_pll_pkg::*;
#(
    parameter logic [31:0] K_PAL         = K_PAL_DEFAULT,
    parameter logic [31:0] K_NTSC        = K_NTSC_DEFAULT,
    parameter logic [31:0] K_BUS         = K_BUS_DEFAULT,
    parameter int          STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ntsc,
    input  logic        model,
    input  logic        cfg_waitrequest,
    output logic        cfg_write,
    output logic [5:0]  cfg_address,
    output logic [31:0] cfg_data,
    output logic        busy,
    output logic        done
);

    pll_state_e  r_state;
    pll_state_e  w_state_next;

    logic [1:0]  w_sel_acc;
    logic        w_sel_valid;
    logic [1:0]  r_applied_sel;
    logic [31:0] r_k;
    logic        r_rst_req;
    logic        w_req;
    logic        w_start;

    logic        r_write;
    logic [5:0]  r_addr;
    logic [31:0] r_data;
    logic        r_busy;
    logic        r_done;
    logic        w_write_next;
    logic [5:0]  w_addr_next;
    logic [31:0] w_data_next;

    sel_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ntsc      (ntsc),
        .model     (model),
        .sel_acc   (w_sel_acc),
        .sel_valid (w_sel_valid)
    );

    // Evaluated only in IDLE, so changes during a sequence collapse to the latest value
    assign w_req = w_sel_valid && (r_rst_req || (w_sel_acc != r_applied_sel));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_write_next = 1'b0;
        w_addr_next  = 6'd0;
        w_data_next  = 32'd0;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_next = WR_MODE;
                    w_start      = 1'b1;
                end
            end
            WR_MODE:   if (!cfg_waitrequest) w_state_next = GAP1;
            GAP1:      w_state_next = WR_FRAC;
            WR_FRAC:   if (!cfg_waitrequest) w_state_next = GAP2;
            GAP2:      w_state_next = WR_START;
            WR_START:  if (!cfg_waitrequest) w_state_next = WAIT_DONE;
            WAIT_DONE: if (!cfg_waitrequest) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase

        // Bus outputs are registered from the state being entered
        case (w_state_next)
            WR_MODE: begin
                w_write_next = 1'b1;
                w_addr_next  = ADDR_MODE;
            end
            WR_FRAC: begin
                w_write_next = 1'b1;
                w_addr_next  = ADDR_FRAC;
                w_data_next  = r_k;
            end
            WR_START: begin
                w_write_next = 1'b1;
                w_addr_next  = ADDR_START;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write       <= 1'b0;
            r_addr        <= 6'd0;
            r_data        <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_applied_sel <= 2'b00;
            r_k           <= 32'd0;
            r_rst_req     <= 1'b1;
        end else begin
            r_write <= w_write_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
            r_busy  <= (w_state_next != IDLE);
            r_done  <= (r_state == WAIT_DONE) && (w_state_next == IDLE);
            if (w_start) begin
                r_applied_sel <= w_sel_acc;
                r_k           <= select_k(w_sel_acc, K_PAL, K_NTSC, K_BUS);
                r_rst_req     <= 1'b0;
            end
        end
    end

    assign cfg_write   = r_write;
    assign cfg_address = r_addr;
    assign cfg_data    = r_data;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_pll_reconf_seq.sv
// tb/tb_pll_reconf_seq.sv - directed self-checking bench for pll_reconf_seq
module tb_pll_reconf_seq;

    localparam logic [31:0] KP = 32'd1503512573;
    localparam logic [31:0] KN = 32'd3357876127;
    localparam logic [31:0] KB = 32'd0;

    logic        clk = 1'b0;
    logic        reset;
    logic        ntsc;
    logic        model;
    logic        cfg_waitrequest;
    logic        cfg_write;
    logic [5:0]  cfg_address;
    logic [31:0] cfg_data;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int wr_cycles = 0;
    int n;
    int w0;
    logic [37:0] log_q[$];

    always #10 clk = ~clk;

    pll_reconf_seq dut (
        .clk             (clk),
        .reset           (reset),
        .ntsc            (ntsc),
        .model           (model),
        .cfg_waitrequest (cfg_waitrequest),
        .cfg_write       (cfg_write),
        .cfg_address     (cfg_address),
        .cfg_data        (cfg_data),
        .busy            (busy),
        .done            (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Samples what the DUT will see at the next rising edge
    always @(negedge clk) begin
        #3;
        if (!reset) begin
            if (cfg_write) begin
                wr_cycles++;
                if (!cfg_waitrequest)
                    log_q.push_back({cfg_address, cfg_data});
            end else begin
                check("bus_zero_when_idle", 64'({cfg_address, cfg_data}), 64'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cyc++;
            if (done) break;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic wait_wr(input logic [5:0] a, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (cfg_write && cfg_address == a) break;
        end
        check("write_seen", 64'(cfg_write && cfg_address == a), 64'd1);
    endtask

    task automatic check_seq(input string tag, input logic [31:0] k);
        check({tag, "_nwrites"}, 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            check({tag, "_w0"}, 64'(log_q[0]), 64'({6'd0, 32'd0}));
            check({tag, "_w1"}, 64'(log_q[1]), 64'({6'd7, k}));
            check({tag, "_w2"}, 64'(log_q[2]), 64'({6'd2, 32'd0}));
        end
    endtask

    // Parks the FSM in WAIT_DONE by raising waitrequest just after WR_START completes
    task automatic stall_in_wait_done();
        wait_wr(6'd2, 40);
        @(posedge clk);
        #1;
        cfg_waitrequest = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        ntsc = 1'b0;
        model = 1'b0;
        cfg_waitrequest = 1'b0;
        repeat (3) tick();
        check("rst_write", 64'(cfg_write), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bus", 64'({cfg_address, cfg_data}), 64'd0);
        check("rst_applied", 64'(dut.r_applied_sel), 64'd0);
        check("rst_filter_cnt", 64'(dut.u_filter.r_cnt), 64'd0);

        // Sequence after reset release for PAL/Professional
        reset = 1'b0;
        log_q.delete();
        wait_done(40, n);
        check("rst_seq_latency", 64'(n), 64'd11);
        check("done_busy_low", 64'(busy), 64'd0);
        check_seq("rst_seq", KP);
        tick();
        check("done_one_cycle", 64'(done), 64'd0);
        repeat (5) tick();
        check("no_extra_seq", 64'(log_q.size()), 64'd3);

        // NTSC select: minimum latency 2 + 4 + 7
        ntsc = 1'b1;
        log_q.delete();
        wait_done(40, n);
        check("ntsc_latency", 64'(n), 64'd13);
        check_seq("ntsc_seq", KN);
        check("ntsc_applied", 64'(dut.r_applied_sel), 64'd1);
        repeat (10) tick();
        check("ntsc_single_seq", 64'(log_q.size()), 64'd3);

        // Two-cycle glitch is filtered out
        w0 = wr_cycles;
        ntsc = 1'b0;
        repeat (2) tick();
        ntsc = 1'b1;
        repeat (20) tick();
        check("glitch_no_write", 64'(wr_cycles - w0), 64'd0);
        check("glitch_not_busy", 64'(busy), 64'd0);

        // waitrequest high for 5 cycles in WR_FRAC
        ntsc = 1'b0;
        log_q.delete();
        wait_wr(6'd0, 40);
        tick();
        check("gap1_no_write", 64'(cfg_write), 64'd0);
        cfg_waitrequest = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("frac_hold", 64'({cfg_write, cfg_address, cfg_data}), 64'({1'b1, 6'd7, KP}));
            if (i == 5) cfg_waitrequest = 1'b0;
        end
        tick();
        check("gap2_no_write", 64'(cfg_write), 64'd0);
        wait_done(40, n);
        check_seq("stall_seq", KP);

        // model change during a held WAIT_DONE queues a Business sequence
        ntsc = 1'b1;
        log_q.delete();
        stall_in_wait_done();
        model = 1'b1;
        repeat (12) tick();
        check("held_wait_busy", 64'({busy, done, cfg_write}), 64'({1'b1, 1'b0, 1'b0}));
        cfg_waitrequest = 1'b0;
        wait_done(5, n);
        check("wait_release_latency", 64'(n), 64'd1);
        check_seq("ntsc2_seq", KN);
        log_q.delete();
        tick();
        check("queued_start", 64'({cfg_write, cfg_address, busy}), 64'({1'b1, 6'd0, 1'b1}));
        wait_done(40, n);
        check("queued_len", 64'(n), 64'd6);
        check_seq("bus_seq", KB);
        check("bus_applied", 64'(dut.r_applied_sel), 64'd3);

        // Accepted sel moves away and back while busy: no follow-up sequence
        ntsc = 1'b0;
        log_q.delete();
        stall_in_wait_done();
        ntsc = 1'b1;
        repeat (10) tick();
        ntsc = 1'b0;
        repeat (10) tick();
        cfg_waitrequest = 1'b0;
        wait_done(5, n);
        check_seq("revert_seq", KB);
        w0 = wr_cycles;
        repeat (20) tick();
        check("revert_no_seq", 64'(wr_cycles - w0), 64'd0);
        check("revert_applied", 64'(dut.r_applied_sel), 64'd2);

        // Reset during GAP2 aborts; a fresh sequence follows release
        model = 1'b0;
        ntsc = 1'b1;
        wait_wr(6'd7, 60);
        tick();
        check("in_gap2", 64'({busy, cfg_write}), 64'({1'b1, 1'b0}));
        reset = 1'b1;
        #1;
        check("abort_outputs", 64'({cfg_write, busy, done, cfg_address, cfg_data}), 64'd0);
        check("abort_applied", 64'(dut.r_applied_sel), 64'd0);
        repeat (3) tick();
        check("abort_no_write", 64'(cfg_write), 64'd0);
        w0 = wr_cycles;
        reset = 1'b0;
        log_q.delete();
        wait_done(40, n);
        check("fresh_latency", 64'(n), 64'd13);
        check_seq("fresh_seq", KN);
        check("fresh_write_cycles", 64'(wr_cycles - w0), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
